// File: rtl/armleocpu_fetch_queue.sv
// armleocpu_fetch_queue: sequential instruction prefetch unit.
// Keeps a small queue of fetched words between the I-cache and decode.
module armleocpu_fetch_queue #(
    parameter int          QUEUE_DEPTH             = 4,
    parameter logic [31:0] RESET_VECTOR            = 32'h0000_2000,
    parameter int          DEBUG_CMD_WIDTH         = 4,
    parameter int          F2E_TYPE_WIDTH          = 2,
    parameter int          ARMLEOCPU_D2F_CMD_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic [3:0]                         c_cmd,
    output logic [31:0]                        c_address,
    input  logic                               c_done,
    input  logic [3:0]                         c_response,
    input  logic [31:0]                        c_load_data,
    input  logic                               interrupt_pending,
    input  logic                               dbg_mode,
    input  logic                               dbg_cmd_valid,
    input  logic [DEBUG_CMD_WIDTH-1:0]         dbg_cmd,
    input  logic [31:0]                        dbg_arg0,
    output logic                               dbg_cmd_ready,
    output logic                               dbg_pipeline_busy,
    output logic                               f2d_valid,
    output logic [F2E_TYPE_WIDTH-1:0]          f2d_type,
    output logic [31:0]                        f2d_instr,
    output logic [31:0]                        f2d_pc,
    output logic [3:0]                         f2d_resp,
    input  logic                               d2f_ready,
    input  logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    input  logic [31:0]                        d2f_branchtarget
);

    localparam logic [3:0] CACHE_CMD_NONE         = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE      = 4'd1;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL    = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_SUCCESS = 4'd0;

    localparam logic [DEBUG_CMD_WIDTH-1:0] DEBUG_CMD_JUMP =
        DEBUG_CMD_WIDTH'(4);

    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR =
        F2E_TYPE_WIDTH'(0);
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING =
        F2E_TYPE_WIDTH'(1);

    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] D2F_START_BRANCH =
        ARMLEOCPU_D2F_CMD_WIDTH'(1);
    localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] D2F_FLUSH =
        ARMLEOCPU_D2F_CMD_WIDTH'(2);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    c_cmd_q, c_cmd_d;
    logic [31:0]   c_address_q, c_address_d;
    logic [31:0]   next_pc_q, next_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          redir_q, redir_d;
    logic [31:0]   redir_tgt_q, redir_tgt_d;
    logic          flush_q, flush_d;
    logic [31:0]   flush_tgt_q, flush_tgt_d;
    logic          drop_q, drop_d;
    logic          halted_q, halted_d;

    logic [31:0] instr_mem [QUEUE_DEPTH];
    logic [31:0] pc_mem    [QUEUE_DEPTH];
    logic [3:0]  resp_mem  [QUEUE_DEPTH];

    logic          busy, exec_out, exec_done, arb;
    logic          dbg_jump, d2f_br, d2f_fl;
    logic          any_new, new_flush;
    logic [31:0]   new_tgt;
    logic          push, pop, err_now, head_v, int_out;
    logic          halted_eff, flush_eff, redir_eff, flush_done;
    logic [31:0]   flush_tgt_eff, redir_tgt_eff;
    logic [CW-1:0] cnt_base, occ_next;

    assign busy      = (c_cmd_q != CACHE_CMD_NONE);
    assign exec_out  = (c_cmd_q == CACHE_CMD_EXECUTE);
    assign exec_done = exec_out && c_done;
    assign arb       = !busy || c_done;

    assign dbg_cmd_ready     = dbg_mode && !busy && dbg_cmd_valid;
    assign dbg_pipeline_busy = busy;

    // A debug jump overrides any decode command arriving alongside it
    assign dbg_jump  = dbg_cmd_ready && (dbg_cmd == DEBUG_CMD_JUMP);
    assign d2f_br    = d2f_ready && (d2f_cmd == D2F_START_BRANCH);
    assign d2f_fl    = d2f_ready && (d2f_cmd == D2F_FLUSH);
    assign any_new   = dbg_jump || d2f_br || d2f_fl;
    assign new_flush = d2f_fl && !dbg_jump;
    assign new_tgt   = dbg_jump ? dbg_arg0 : d2f_branchtarget;

    assign head_v  = (count_q != '0);
    assign push    = exec_done && !drop_q && !any_new;
    assign pop     = head_v && d2f_ready && !any_new;
    assign err_now = push && (c_response != CACHE_RESPONSE_SUCCESS);

    assign halted_eff = (halted_q && !any_new) || err_now;

    // A pending flush absorbs later redirects as its refetch target
    assign flush_eff     = flush_q || new_flush;
    assign flush_tgt_eff = any_new ? new_tgt : flush_tgt_q;
    assign redir_eff     = !flush_eff && (redir_q || any_new);
    assign redir_tgt_eff = any_new ? new_tgt : redir_tgt_q;
    assign flush_done    = (c_cmd_q == CACHE_CMD_FLUSH_ALL) && c_done
                           && !new_flush;

    assign cnt_base = any_new ? '0 : count_q;
    assign occ_next = cnt_base + CW'(push) - CW'(pop);

    assign int_out   = interrupt_pending && !head_v && !exec_out;
    assign f2d_valid = head_v || int_out;
    assign f2d_type  = head_v ? F2E_TYPE_INSTR : F2E_TYPE_INTERRUPT_PENDING;
    assign f2d_instr = instr_mem[rptr_q];
    assign f2d_pc    = head_v ? pc_mem[rptr_q] : next_pc_q;
    assign f2d_resp  = resp_mem[rptr_q];

    assign c_cmd     = c_cmd_q;
    assign c_address = c_address_q;

    // Queue bookkeeping, drop tracking and error stop
    always_comb begin
        count_d  = occ_next;
        rptr_d   = any_new ? '0 : rptr_q + PW'(pop);
        wptr_d   = any_new ? '0 : wptr_q + PW'(push);
        halted_d = halted_eff;
        drop_d   = drop_q;
        if (any_new && exec_out && !c_done)
            drop_d = 1'b1;
        else if (exec_done)
            drop_d = 1'b0;
    end

    // Cache command arbitration, re-evaluated when idle or on completion
    always_comb begin
        c_cmd_d     = c_cmd_q;
        c_address_d = c_address_q;
        next_pc_d   = next_pc_q;
        redir_d     = redir_eff;
        redir_tgt_d = redir_tgt_eff;
        flush_d     = flush_eff;
        flush_tgt_d = flush_tgt_eff;
        if (arb) begin
            if (dbg_mode) begin
                c_cmd_d = CACHE_CMD_NONE;
            end else if (flush_eff && flush_done) begin
                c_cmd_d     = CACHE_CMD_EXECUTE;
                c_address_d = flush_tgt_eff;
                next_pc_d   = flush_tgt_eff + 32'd4;
                flush_d     = 1'b0;
            end else if (flush_eff) begin
                c_cmd_d     = CACHE_CMD_FLUSH_ALL;
                c_address_d = flush_tgt_eff;
            end else if (redir_eff) begin
                c_cmd_d     = CACHE_CMD_EXECUTE;
                c_address_d = redir_tgt_eff;
                next_pc_d   = redir_tgt_eff + 32'd4;
                redir_d     = 1'b0;
            end else if (interrupt_pending || halted_eff) begin
                c_cmd_d = CACHE_CMD_NONE;
            end else if (occ_next < CW'(QUEUE_DEPTH)) begin
                c_cmd_d     = CACHE_CMD_EXECUTE;
                c_address_d = next_pc_q;
                next_pc_d   = next_pc_q + 32'd4;
            end else begin
                c_cmd_d = CACHE_CMD_NONE;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cmd_q     <= CACHE_CMD_NONE;
            c_address_q <= RESET_VECTOR;
            next_pc_q   <= RESET_VECTOR;
            count_q     <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            redir_q     <= 1'b1;
            redir_tgt_q <= RESET_VECTOR;
            flush_q     <= 1'b0;
            flush_tgt_q <= RESET_VECTOR;
            drop_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            c_cmd_q     <= c_cmd_d;
            c_address_q <= c_address_d;
            next_pc_q   <= next_pc_d;
            count_q     <= count_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            redir_q     <= redir_d;
            redir_tgt_q <= redir_tgt_d;
            flush_q     <= flush_d;
            flush_tgt_q <= flush_tgt_d;
            drop_q      <= drop_d;
            halted_q    <= halted_d;
        end
    end

    // Queue storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wptr_q] <= c_load_data;
            pc_mem[wptr_q]    <= c_address_q;
            resp_mem[wptr_q]  <= c_response;
        end
    end

endmodule

// File: tb/tb_armleocpu_fetch_queue.sv
// tb_armleocpu_fetch_queue: directed bench with a cache model and
// an expected-instruction scoreboard tagged by redirect epoch.
module tb_armleocpu_fetch_queue;

    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_EXEC  = 4'd1;
    localparam logic [3:0] C_FLUSH = 4'd4;
    localparam logic [3:0] DBG_JUMP = 4'd4;
    localparam logic [1:0] T_INSTR = 2'd0;
    localparam logic [1:0] T_INT   = 2'd1;
    localparam logic [1:0] D_NONE  = 2'd0;
    localparam logic [1:0] D_BR    = 2'd1;
    localparam logic [1:0] D_FL    = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  c_cmd;
    logic [31:0] c_address;
    logic        c_done;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;
    logic        interrupt_pending;
    logic        dbg_mode;
    logic        dbg_cmd_valid;
    logic [3:0]  dbg_cmd;
    logic [31:0] dbg_arg0;
    logic        dbg_cmd_ready;
    logic        dbg_pipeline_busy;
    logic        f2d_valid;
    logic [1:0]  f2d_type;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
    logic [3:0]  f2d_resp;
    logic        d2f_ready;
    logic [1:0]  d2f_cmd;
    logic [31:0] d2f_branchtarget;

    armleocpu_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .c_cmd(c_cmd), .c_address(c_address),
        .c_done(c_done), .c_response(c_response),
        .c_load_data(c_load_data),
        .interrupt_pending(interrupt_pending),
        .dbg_mode(dbg_mode), .dbg_cmd_valid(dbg_cmd_valid),
        .dbg_cmd(dbg_cmd), .dbg_arg0(dbg_arg0),
        .dbg_cmd_ready(dbg_cmd_ready),
        .dbg_pipeline_busy(dbg_pipeline_busy),
        .f2d_valid(f2d_valid), .f2d_type(f2d_type),
        .f2d_instr(f2d_instr), .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
        .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd),
        .d2f_branchtarget(d2f_branchtarget)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  resp;
        logic [7:0]  ep;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } iss_t;

    exp_t exp_q[$];
    iss_t log_q[$];

    int          ncmp = 0;
    int          nfail = 0;
    int          ndeliv = 0;
    logic [7:0]  epoch = 8'd0;
    logic [31:0] cyc = 32'd0;
    int          lat = 0;
    bit          lat_chk = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic [3:0]  last_resp = 4'h0;

    bit          cbusy = 1'b0;
    int          cwait = 0;
    logic [7:0]  cep;
    logic [31:0] caddr;
    logic [3:0]  ccmd;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Delivery monitor, then the cache responder
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && f2d_valid && d2f_ready && f2d_type == T_INSTR &&
            d2f_cmd == D_NONE &&
            !(dbg_cmd_ready && dbg_cmd == DBG_JUMP)) begin
            while (exp_q.size() > 0 && exp_q[0].ep != epoch)
                void'(exp_q.pop_front());
            ncmp++;
            assert (exp_q.size() > 0) else begin
                nfail++;
                $error("FAIL sb_extra: observed pc %h expected none",
                       f2d_pc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("f2d_pc", 64'(f2d_pc), 64'(e.pc));
                check("f2d_instr", 64'(f2d_instr), 64'(e.instr));
                check("f2d_resp", 64'(f2d_resp), 64'(e.resp));
                if (lat_chk)
                    check("latency", 64'(cyc - e.cyc), 64'd1);
                ndeliv++;
                last_pc = f2d_pc;
                last_resp = f2d_resp;
            end
        end
        c_done = 1'b0;
        if (!rst_n) begin
            cbusy = 1'b0;
        end else if (cbusy || c_cmd != C_NONE) begin
            if (cbusy) begin
                check("c_stable", {28'h0, c_cmd, c_address},
                      {28'h0, ccmd, caddr});
            end else begin
                cbusy = 1'b1;
                cwait = lat;
                cep = epoch;
                caddr = c_address;
                ccmd = c_cmd;
                log_q.push_back('{cmd: c_cmd, addr: c_address});
            end
            if (cwait == 0) begin
                c_done = 1'b1;
                c_response = (err_en && caddr == err_addr) ? 4'd2 : 4'd0;
                c_load_data = word_of(caddr);
                if (ccmd == C_EXEC)
                    exp_q.push_back('{pc: caddr, instr: word_of(caddr),
                                      resp: c_response, ep: cep,
                                      cyc: cyc});
                cbusy = 1'b0;
            end else begin
                cwait--;
            end
        end
    end

    task automatic wait_log(input int n);
        for (int i = 0; i < 200 && log_q.size() < n; i++)
            @(posedge clk);
        ncmp++;
        assert (log_q.size() >= n) else begin
            nfail++;
            $error("FAIL issue_wait: observed %0d cmds expected %0d",
                   log_q.size(), n);
        end
    endtask

    task automatic expect_issue(input logic [3:0] cmd,
                                input logic [31:0] addr,
                                input bit chka);
        iss_t s;
        wait_log(1);
        if (log_q.size() > 0) begin
            s = log_q.pop_front();
            check("issue_cmd", 64'(s.cmd), 64'(cmd));
            if (chka)
                check("issue_addr", 64'(s.addr), 64'(addr));
        end
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (f2d_valid) break;
        end
        check("valid_wait", 64'(f2d_valid), 64'd1);
    endtask

    task automatic branch(input logic [1:0] cmd, input logic [31:0] t);
        d2f_cmd = cmd;
        d2f_branchtarget = t;
        d2f_ready = 1'b1;
        @(posedge clk); #1;
        d2f_cmd = D_NONE;
        epoch++;
    endtask

    task automatic do_reset(input bit rdy, input int l);
        @(posedge clk); #1;
        rst_n = 1'b0;
        d2f_ready = 1'b0;
        d2f_cmd = D_NONE;
        interrupt_pending = 1'b0;
        dbg_mode = 1'b0;
        dbg_cmd_valid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        log_q.delete();
        epoch++;
        @(negedge clk);
        check("rst_c_cmd", 64'(c_cmd), 64'(C_NONE));
        check("rst_c_addr", 64'(c_address), 64'h2000);
        check("rst_f2d_valid", 64'(f2d_valid), 64'd0);
        check("rst_dbg_ready", 64'(dbg_cmd_ready), 64'd0);
        check("rst_dbg_busy", 64'(dbg_pipeline_busy), 64'd0);
        @(posedge clk); #1;
        d2f_ready = rdy;
        lat = l;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int rc;
        rst_n = 1'b0;
        c_done = 1'b0;
        c_response = 4'h0;
        c_load_data = 32'h0;
        interrupt_pending = 1'b0;
        dbg_mode = 1'b0;
        dbg_cmd_valid = 1'b0;
        dbg_cmd = 4'h0;
        dbg_arg0 = 32'h0;
        d2f_ready = 1'b0;
        d2f_cmd = D_NONE;
        d2f_branchtarget = 32'h0;

        // Streaming with a single-cycle cache
        do_reset(1'b1, 0);
        lat_chk = 1'b1;
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        expect_issue(C_EXEC, 32'h2008, 1'b1);
        repeat (6) @(posedge clk);
        #1 lat_chk = 1'b0;

        // Decode stalled: queue fills, then drains in order
        do_reset(1'b0, 0);
        repeat (12) @(posedge clk);
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        expect_issue(C_EXEC, 32'h2008, 1'b1);
        expect_issue(C_EXEC, 32'h200C, 1'b1);
        check("full_no_issue", 64'(log_q.size()), 64'd0);
        @(negedge clk);
        check("full_c_cmd", 64'(c_cmd), 64'(C_NONE));
        check("full_valid", 64'(f2d_valid), 64'd1);
        check("full_head_pc", 64'(f2d_pc), 64'h2000);
        @(posedge clk); #1;
        n0 = ndeliv;
        d2f_ready = 1'b1;
        expect_issue(C_EXEC, 32'h2010, 1'b1);
        repeat (6) @(posedge clk);
        check("drain_count", 64'(ndeliv - n0 >= 4), 64'd1);

        // Branch while an EXECUTE is outstanding
        do_reset(1'b0, 2);
        wait_log(3);
        #1 branch(D_BR, 32'h8000);
        @(negedge clk);
        check("br_empty", 64'(f2d_valid), 64'd0);
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        expect_issue(C_EXEC, 32'h2008, 1'b1);
        expect_issue(C_EXEC, 32'h8000, 1'b1);
        wait_valid();
        check("br_first_pc", 64'(f2d_pc), 64'h8000);

        // Flush with refetch address
        do_reset(1'b1, 2);
        wait_log(2);
        #1 branch(D_FL, 32'h3000);
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        expect_issue(C_FLUSH, 32'h0, 1'b0);
        expect_issue(C_EXEC, 32'h3000, 1'b1);
        wait_valid();
        check("fl_first_pc", 64'(f2d_pc), 64'h3000);
        expect_issue(C_EXEC, 32'h3004, 1'b1);

        // Error response stops sequential fetch
        err_en = 1'b1;
        err_addr = 32'h2004;
        do_reset(1'b1, 0);
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        repeat (6) @(posedge clk);
        check("err_no_issue", 64'(log_q.size()), 64'd0);
        check("err_last_pc", 64'(last_pc), 64'h2004);
        check("err_last_resp", 64'(last_resp), 64'd2);
        @(negedge clk);
        check("err_c_cmd", 64'(c_cmd), 64'(C_NONE));
        @(posedge clk); #1;
        err_en = 1'b0;
        branch(D_BR, 32'h100);
        expect_issue(C_EXEC, 32'h100, 1'b1);
        expect_issue(C_EXEC, 32'h104, 1'b1);

        // Interrupt: drain, then report with next pc
        do_reset(1'b0, 1);
        wait_log(2);
        #1 interrupt_pending = 1'b1;
        repeat (3) @(posedge clk);
        #1 n0 = ndeliv;
        d2f_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (f2d_valid && f2d_type == T_INT) break;
        end
        check("int_valid", 64'(f2d_valid), 64'd1);
        check("int_type", 64'(f2d_type), 64'(T_INT));
        check("int_pc", 64'(f2d_pc), 64'h2008);
        check("int_drained", 64'(ndeliv - n0), 64'd2);
        expect_issue(C_EXEC, 32'h2000, 1'b1);
        expect_issue(C_EXEC, 32'h2004, 1'b1);
        check("int_no_issue", 64'(log_q.size()), 64'd0);
        @(posedge clk); #1;
        interrupt_pending = 1'b0;
        expect_issue(C_EXEC, 32'h2008, 1'b1);

        // Debug halt and jump
        do_reset(1'b1, 1);
        repeat (5) @(posedge clk);
        #1;
        dbg_mode = 1'b1;
        dbg_cmd_valid = 1'b1;
        dbg_cmd = DBG_JUMP;
        dbg_arg0 = 32'h400;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dbg_cmd_ready) break;
        end
        check("dbg_ready", 64'(dbg_cmd_ready), 64'd1);
        check("dbg_idle", 64'(dbg_pipeline_busy), 64'd0);
        @(posedge clk); #1;
        dbg_cmd_valid = 1'b0;
        epoch++;
        rc = 0;
        repeat (4) begin
            @(negedge clk);
            if (dbg_cmd_ready) rc++;
        end
        check("dbg_one_pulse", 64'(rc), 64'd0);
        check("dbg_c_cmd", 64'(c_cmd), 64'(C_NONE));
        check("dbg_flushed", 64'(f2d_valid), 64'd0);
        log_q.delete();
        @(posedge clk); #1;
        dbg_mode = 1'b0;
        expect_issue(C_EXEC, 32'h400, 1'b1);
        wait_valid();
        check("dbg_first_pc", 64'(f2d_pc), 64'h400);
        expect_issue(C_EXEC, 32'h404, 1'b1);
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
